// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data, parity and stop framing
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [AW:0]          fifo_count
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST_B = CW'(BAUD_DIV - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, head;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                 push, pop, bit_end;

  assign in_ready   = cnt_q != FULL;
  assign push       = in_valid & in_ready;
  assign head       = mem_q[rd_q];
  assign bit_end    = baud_q == LAST_B;
  assign cnt_d      = (push & ~pop) ? cnt_q + 1'b1 : (pop & ~push) ? cnt_q - 1'b1 : cnt_q;
  assign fifo_count = cnt_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

  // FIFO storage; pointer reset alone makes stale contents unreachable
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // framing FSM next state; outputs are decoded from the current state and registered
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          sh_d    = head;
          par_d   = (PARITY == 1) ? ~^head : ^head;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_D) begin
            state_d = (PARITY != 0) ? PAR : STOP;
            bit_d   = '0;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_S) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d   = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : (state_q == PAR) ? par_q : 1'b1;
    busy_d = state_q != IDLE;
    done_d = (state_q == STOP) && bit_end && (bit_q == LAST_S);
  end

  // FSM state, bit timing and registered line outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed vectors across four framing configurations plus FIFO and reset sequences
module tb_uart_tx_fifo;
  logic       clk, rstn;
  logic       vld [4];
  logic [8:0] din [4];
  logic       rdy [4], tx_w [4], busy [4], done [4];
  logic [2:0] cnt [4];
  int         checks, errors, cyc;
  logic [7:0] rx_q [$];
  int         rx_st [$];
  int         rx_bad;

  typedef struct {
    int         d;
    logic [8:0] data;
    logic       par;
    int         len;
  } vec_t;
  vec_t tv [9];
  int db [4] = '{8, 8, 8, 7};
  int pe [4] = '{0, 1, 1, 0};
  int sb [4] = '{1, 1, 1, 2};

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rstn(rstn), .in_valid(vld[0]), .in_data(din[0][7:0]), .in_ready(rdy[0]),
    .tx(tx_w[0]), .tx_busy(busy[0]), .tx_done(done[0]), .fifo_count(cnt[0]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(vld[1]), .in_data(din[1][7:0]), .in_ready(rdy[1]),
    .tx(tx_w[1]), .tx_busy(busy[1]), .tx_done(done[1]), .fifo_count(cnt[1]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rstn(rstn), .in_valid(vld[2]), .in_data(din[2][7:0]), .in_ready(rdy[2]),
    .tx(tx_w[2]), .tx_busy(busy[2]), .tx_done(done[2]), .fifo_count(cnt[2]));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rstn(rstn), .in_valid(vld[3]), .in_data(din[3][6:0]), .in_ready(rdy[3]),
    .tx(tx_w[3]), .tx_busy(busy[3]), .tx_done(done[3]), .fifo_count(cnt[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(int d, logic [8:0] w);
    vld[d] = 1'b1;
    din[d] = w;
    for (int k = 0; k < 2000 && !rdy[d]; k++) tick();
    chk("push_ready", 32'(rdy[d]), 1);
    tick();
    vld[d] = 1'b0;
  endtask

  // 8N1 line receiver on instance 0: records each word and the cycle its start bit appeared
  initial begin
    logic [7:0] b;
    int st;
    b = '0;
    forever begin
      tick();
      if (rstn && tx_w[0] === 1'b0) begin
        st = cyc;
        repeat (14) tick();
        for (int i = 0; i < 8; i++) begin
          b[i] = tx_w[0];
          repeat (10) tick();
        end
        if (tx_w[0] !== 1'b1) rx_bad++;
        repeat (5) tick();
        rx_q.push_back(b);
        rx_st.push_back(st);
      end
    end
  end

  initial begin
    logic [11:0] line;
    logic [7:0]  w4 [6];
    int d, a0, a5, len;
    checks = 0; errors = 0; cyc = 0; rx_bad = 0;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin vld[i] = 1'b0; din[i] = '0; end
    tv[0] = '{0, 9'h0A5, 1'b0, 100};
    tv[1] = '{1, 9'h007, 1'b1, 110};
    tv[2] = '{2, 9'h007, 1'b0, 110};
    tv[3] = '{3, 9'h055, 1'b0, 100};
    tv[4] = '{0, 9'h000, 1'b0, 100};
    tv[5] = '{1, 9'h0FF, 1'b0, 110};
    tv[6] = '{2, 9'h000, 1'b1, 110};
    tv[7] = '{3, 9'h07F, 1'b0, 100};
    tv[8] = '{1, 9'h001, 1'b1, 110};
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", 32'(tx_w[i]), 1);
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_done", 32'(done[i]), 0);
      chk("rst_cnt", 32'(cnt[i]), 0);
      chk("rst_ready", 32'(rdy[i]), 1);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) tick();

    for (int v = 0; v < 9; v++) begin
      d = tv[v].d;
      len = tv[v].len;
      line = '1;
      line[0] = 1'b0;
      for (int i = 0; i < db[d]; i++) line[1+i] = tv[v].data[i];
      if (pe[d] != 0) line[1+db[d]] = tv[v].par;
      chk("frame_len", 32'((1 + db[d] + pe[d] + sb[d]) * 10), 32'(len));
      vld[d] = 1'b1;
      din[d] = tv[v].data;
      chk("vec_ready", 32'(rdy[d]), 1);
      tick();
      vld[d] = 1'b0;
      chk("vec_cnt_acc", 32'(cnt[d]), 1);
      tick();
      chk("vec_lat_tx", 32'(tx_w[d]), 1);
      chk("vec_cnt_pop", 32'(cnt[d]), 0);
      for (int c = 1; c <= len; c++) begin
        tick();
        chk("vec_bit", 32'(tx_w[d]), 32'(line[(c-1)/10]));
        chk("vec_busy", 32'(busy[d]), 1);
        chk("vec_done", 32'(done[d]), 32'(c == len));
      end
      tick();
      chk("vec_idle_tx", 32'(tx_w[d]), 1);
      chk("vec_idle_busy", 32'(busy[d]), 0);
      chk("vec_idle_done", 32'(done[d]), 0);
      repeat (3) tick();
    end

    rx_q.delete();
    rx_st.delete();
    rx_bad = 0;
    w4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    push(0, {1'b0, w4[0]});
    a0 = cyc;
    for (int i = 1; i < 5; i++) push(0, {1'b0, w4[i]});
    chk("full_cnt", 32'(cnt[0]), 4);
    chk("full_ready", 32'(rdy[0]), 0);
    push(0, {1'b0, w4[5]});
    a5 = cyc;
    chk("fifth_accept_edge", 32'(a5 - a0), 103);
    for (int k = 0; k < 1000 && rx_q.size() < 6; k++) tick();
    chk("burst_frames", 32'(rx_q.size()), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) chk("burst_word", 32'(rx_q[i]), 32'(w4[i]));
    for (int i = 1; i < 6 && i < rx_st.size(); i++) chk("burst_gap", 32'(rx_st[i] - rx_st[i-1]), 101);
    chk("burst_stop", 32'(rx_bad), 0);
    repeat (5) tick();

    rx_q.delete();
    rx_st.delete();
    push(0, 9'h0C1);
    push(0, 9'h0C2);
    push(0, 9'h0C3);
    repeat (99) tick();
    chk("pp_cnt_before", 32'(cnt[0]), 2);
    push(0, 9'h0C4);
    chk("pp_cnt_after", 32'(cnt[0]), 2);
    for (int k = 0; k < 1000 && rx_q.size() < 4; k++) tick();
    chk("pp_frames", 32'(rx_q.size()), 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("pp_word", 32'(rx_q[i]), 32'(8'hC1 + i));
    for (int i = 1; i < 4 && i < rx_st.size(); i++) chk("pp_gap", 32'(rx_st[i] - rx_st[i-1]), 101);
    repeat (5) tick();

    for (int i = 0; i < 4; i++) push(0, 9'h0F0 + 9'(i));
    chk("abort_queued", 32'(cnt[0]), 3);
    repeat (30) tick();
    chk("abort_busy_pre", 32'(busy[0]), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_tx", 32'(tx_w[0]), 1);
    chk("abort_cnt", 32'(cnt[0]), 0);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_ready", 32'(rdy[0]), 1);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 150; c++) begin
      tick();
      chk("post_abort_tx", 32'(tx_w[0]), 1);
      chk("post_abort_busy", 32'(busy[0]), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
